turn_sequencer: RTL and testbench

Top-level turn controller for the two-player artillery game. It sequences one player's turn through angle select, power select and projectile flight, and enables exactly one input/animation block at a time. It latches the chosen angle and power, keeps score, and alternates players. It also multiplexes the active block's x/y/color onto the single VGA plotter port.

---
 rtl/turn_pkg.sv | 19 +
 rtl/rise_detect.sv | 22 ++
 rtl/turn_sequencer.sv | 141 ++++++++++++++
 tb/tb_turn_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/turn_pkg.sv
// Shared types and field widths for the artillery-game turn controller.
package turn_pkg;

  localparam int SCORE_W = 3;
  localparam int ANG_W   = 8;
  localparam int X_W     = 8;
  localparam int Y_W     = 7;
  localparam int C_W     = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ANGLE,
    ST_POWER,
    ST_FIRE,
    ST_RESULT,
    ST_OVER
  } state_t;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: a 0->1 on 'in' yields a one-cycle 'rise' on the following cycle.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic in_d;

  // NOTE: sequential state always uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_d <= 1'b0;
      rise <= 1'b0;
    end else begin
      in_d <= in;
      rise <= in & ~in_d;
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Turn controller: steps a player through angle, power and flight, keeps score and muxes plot data.
module turn_sequencer
  import turn_pkg::*;
#(
  parameter int RESULT_CYCLES = 50_000_000,
  parameter int WIN_SCORE     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [ANG_W-1:0]   angle_in,
  input  logic [X_W-1:0]     ang_x,
  input  logic [Y_W-1:0]     ang_y,
  input  logic [C_W-1:0]     ang_color,
  input  logic [ANG_W-1:0]   power_in,
  input  logic [X_W-1:0]     pow_x,
  input  logic [Y_W-1:0]     pow_y,
  input  logic [C_W-1:0]     pow_color,
  input  logic [X_W-1:0]     fire_x,
  input  logic [Y_W-1:0]     fire_y,
  input  logic [C_W-1:0]     fire_color,
  input  logic               fire_done,
  input  logic               hit,
  output logic               angle_en,
  output logic               power_en,
  output logic               fire_en,
  output logic [ANG_W-1:0]   angle_q,
  output logic [ANG_W-1:0]   power_q,
  output logic               player,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic               winner_valid,
  output logic [X_W-1:0]     plot_x,
  output logic [Y_W-1:0]     plot_y,
  output logic [C_W-1:0]     plot_color,
  output logic               plot
);

  localparam int CNT_W = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(RESULT_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

  state_t           state, state_d;
  logic             go_rise;
  logic [CNT_W-1:0] cnt;
  logic             game_won;

  rise_detect u_go_edge (
    .clk   (clk),
    .reset (reset),
    .in    (go),
    .rise  (go_rise)
  );

  assign game_won = (score0 == WIN) || (score1 == WIN);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state;
    angle_en     = 1'b0;
    power_en     = 1'b0;
    fire_en      = 1'b0;
    winner_valid = 1'b0;
    plot         = 1'b0;
    plot_x       = '0;
    plot_y       = '0;
    plot_color   = '0;
    case (state)
      ST_IDLE: if (go_rise) state_d = ST_ANGLE;
      ST_ANGLE: begin
        angle_en   = 1'b1;
        plot       = 1'b1;
        plot_x     = ang_x;
        plot_y     = ang_y;
        plot_color = ang_color;
        if (go_rise) state_d = ST_POWER;
      end
      ST_POWER: begin
        power_en   = 1'b1;
        plot       = 1'b1;
        plot_x     = pow_x;
        plot_y     = pow_y;
        plot_color = pow_color;
        if (go_rise) state_d = ST_FIRE;
      end
      ST_FIRE: begin
        fire_en    = 1'b1;
        plot       = 1'b1;
        plot_x     = fire_x;
        plot_y     = fire_y;
        plot_color = fire_color;
        if (fire_done) state_d = ST_RESULT;
      end
      ST_RESULT: if (cnt == CNT_LAST) state_d = game_won ? ST_OVER : ST_ANGLE;
      ST_OVER: begin
        winner_valid = 1'b1;
        if (go_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      angle_q <= '0;
      power_q <= '0;
      player  <= 1'b0;
      score0  <= '0;
      score1  <= '0;
      cnt     <= '0;
    end else begin
      state <= state_d;
      case (state)
        ST_ANGLE: if (go_rise) angle_q <= angle_in;
        ST_POWER: if (go_rise) power_q <= power_in;
        ST_FIRE: begin
          cnt <= '0;
          // Scores saturate at the winning value; the game ends before they could pass it.
          if (fire_done && hit) begin
            if (!player && score0 < WIN) score0 <= score0 + 1'b1;
            if (player && score1 < WIN)  score1 <= score1 + 1'b1;
          end
        end
        ST_RESULT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST && !game_won) player <= ~player;
        end
        ST_OVER: begin
          if (go_rise) begin
            score0 <= '0;
            score1 <= '0;
            player <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer with a short RESULT hold and first-to-3 scoring.
module tb_turn_sequencer;

  localparam int RC = 10;

  logic       clk = 1'b0;
  logic       reset, go, fire_done, hit;
  logic [7:0] angle_in, power_in;
  logic [7:0] ang_x, pow_x, fire_x;
  logic [6:0] ang_y, pow_y, fire_y;
  logic [2:0] ang_color, pow_color, fire_color;
  logic       angle_en, power_en, fire_en, player, winner_valid, plot;
  logic [7:0] angle_q, power_q, plot_x;
  logic [6:0] plot_y;
  logic [2:0] score0, score1, plot_color;

  int checks = 0;
  int errors = 0;

  turn_sequencer #(.RESULT_CYCLES(RC), .WIN_SCORE(3)) dut (
    .clk(clk), .reset(reset), .go(go),
    .angle_in(angle_in), .ang_x(ang_x), .ang_y(ang_y), .ang_color(ang_color),
    .power_in(power_in), .pow_x(pow_x), .pow_y(pow_y), .pow_color(pow_color),
    .fire_x(fire_x), .fire_y(fire_y), .fire_color(fire_color),
    .fire_done(fire_done), .hit(hit),
    .angle_en(angle_en), .power_en(power_en), .fire_en(fire_en),
    .angle_q(angle_q), .power_q(power_q), .player(player),
    .score0(score0), .score1(score1), .winner_valid(winner_valid),
    .plot_x(plot_x), .plot_y(plot_y), .plot_color(plot_color), .plot(plot)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    go = 1'b1;
    step();
    go = 1'b0;
    step();
  endtask

  // Observed enables/plot packed as {angle_en,power_en,fire_en,winner_valid,plot}
  function automatic logic [4:0] flags();
    return {angle_en, power_en, fire_en, winner_valid, plot};
  endfunction

  task automatic test_reset();
    reset = 1'b1; go = 1'b0; fire_done = 1'b0; hit = 1'b0;
    step(); step();
    reset = 1'b0;
    checks++;
    if (flags() !== 5'b00000) begin
      errors++; $display("FAIL reset_flags got %b want 00000", flags());
    end
    checks++;
    if ({angle_q, power_q, player, score0, score1} !== 23'd0) begin
      errors++; $display("FAIL reset_regs got aq=%0d pq=%0d p=%0d s0=%0d s1=%0d want all 0",
                         angle_q, power_q, player, score0, score1);
    end
    checks++;
    if ({plot_x, plot_y, plot_color} !== 18'd0) begin
      errors++; $display("FAIL reset_plot got %h want 0", {plot_x, plot_y, plot_color});
    end
  endtask

  task automatic test_go_to_angle();
    go = 1'b1;
    step();
    checks++;
    if (angle_en !== 1'b0) begin
      errors++; $display("FAIL angle_latency got angle_en=%b want 0 one cycle after go", angle_en);
    end
    go = 1'b0;
    step();
    checks++;
    if (flags() !== 5'b10001) begin
      errors++; $display("FAIL idle_to_angle got %b want 10001", flags());
    end
    checks++;
    if ({plot_x, plot_y, plot_color} !== {8'h11, 7'h22, 3'd1}) begin
      errors++; $display("FAIL angle_plot got %h want %h", {plot_x, plot_y, plot_color}, {8'h11, 7'h22, 3'd1});
    end
    checks++;
    if ({angle_q, power_q, player, score0, score1} !== 23'd0) begin
      errors++; $display("FAIL angle_regs got aq=%0d p=%0d want 0", angle_q, player);
    end
  endtask

  task automatic test_angle_power_capture();
    angle_in = 8'd45;
    press();
    angle_in = 8'd50;
    checks++;
    if (angle_q !== 8'd45) begin
      errors++; $display("FAIL angle_capture got %0d want 45", angle_q);
    end
    checks++;
    if (flags() !== 5'b01001) begin
      errors++; $display("FAIL angle_to_power got %b want 01001", flags());
    end
    checks++;
    if ({plot_x, plot_y, plot_color} !== {8'h33, 7'h44, 3'd2}) begin
      errors++; $display("FAIL power_plot got %h want %h", {plot_x, plot_y, plot_color}, {8'h33, 7'h44, 3'd2});
    end
    power_in = 8'd77;
    press();
    power_in = 8'd12;
    checks++;
    if (power_q !== 8'd77 || angle_q !== 8'd45) begin
      errors++; $display("FAIL power_capture got pq=%0d aq=%0d want 77 45", power_q, angle_q);
    end
    checks++;
    if (flags() !== 5'b00101 || plot_x !== 8'h55 || plot_color !== 3'd3) begin
      errors++; $display("FAIL power_to_fire got %b x=%h want 00101 x=55", flags(), plot_x);
    end
  endtask

  task automatic test_ignore_go_in_fire();
    press();
    press();
    checks++;
    if (flags() !== 5'b00101) begin
      errors++; $display("FAIL go_in_fire got %b want 00101", flags());
    end
  endtask

  task automatic test_hit_and_result();
    fire_done = 1'b1; hit = 1'b1;
    step();
    fire_done = 1'b0; hit = 1'b0;
    checks++;
    if (score0 !== 3'd1 || score1 !== 3'd0 || flags() !== 5'b00000 || plot_x !== 8'h00) begin
      errors++; $display("FAIL hit_p0 got s0=%0d s1=%0d flags=%b x=%h want 1 0 00000 00",
                         score0, score1, flags(), plot_x);
    end
    // go and a stray hit during RESULT must both be ignored
    go = 1'b1; fire_done = 1'b1; hit = 1'b1;
    step();
    go = 1'b0; fire_done = 1'b0; hit = 1'b0;
    repeat (RC - 2) step();
    checks++;
    if (flags() !== 5'b00000 || player !== 1'b0 || score0 !== 3'd1 || score1 !== 3'd0) begin
      errors++; $display("FAIL result_hold got flags=%b p=%0d s0=%0d s1=%0d want 00000 0 1 0",
                         flags(), player, score0, score1);
    end
    step();
    checks++;
    if (flags() !== 5'b10001 || player !== 1'b1) begin
      errors++; $display("FAIL result_exit got flags=%b p=%0d want 10001 1", flags(), player);
    end
  endtask

  task automatic test_hold_go();
    go = 1'b1;
    repeat (20) step();
    checks++;
    if (flags() !== 5'b01001) begin
      errors++; $display("FAIL hold_go got %b want 01001", flags());
    end
    go = 1'b0;
    step();
    press();
    fire_done = 1'b1; hit = 1'b1;
    step();
    fire_done = 1'b0; hit = 1'b0;
    checks++;
    if (score1 !== 3'd1 || score0 !== 3'd1) begin
      errors++; $display("FAIL hit_p1 got s0=%0d s1=%0d want 1 1", score0, score1);
    end
    repeat (RC) step();
    checks++;
    if (player !== 1'b0 || angle_en !== 1'b1) begin
      errors++; $display("FAIL turn_back_p0 got p=%0d ae=%b want 0 1", player, angle_en);
    end
  endtask

  // Plays one turn from ANGLE through to the end of RESULT
  task automatic play_round(input logic h);
    press();
    press();
    fire_done = 1'b1; hit = h;
    step();
    fire_done = 1'b0; hit = 1'b0;
    repeat (RC) step();
  endtask

  task automatic test_win();
    play_round(1'b0);
    play_round(1'b1);
    play_round(1'b0);
    checks++;
    if (score1 !== 3'd2 || score0 !== 3'd1 || player !== 1'b1 || winner_valid !== 1'b0) begin
      errors++; $display("FAIL pre_win got s0=%0d s1=%0d p=%0d wv=%b want 1 2 1 0",
                         score0, score1, player, winner_valid);
    end
    play_round(1'b1);
    checks++;
    if (flags() !== 5'b00010 || player !== 1'b1 || score1 !== 3'd3 || score0 !== 3'd1) begin
      errors++; $display("FAIL game_over got flags=%b p=%0d s0=%0d s1=%0d want 00010 1 1 3",
                         flags(), player, score0, score1);
    end
    press();
    checks++;
    if (flags() !== 5'b00000 || player !== 1'b0 || score0 !== 3'd0 || score1 !== 3'd0) begin
      errors++; $display("FAIL over_to_idle got flags=%b p=%0d s0=%0d s1=%0d want 00000 0 0 0",
                         flags(), player, score0, score1);
    end
  endtask

  task automatic test_reset_mid_fire();
    press();
    play_round(1'b1);
    play_round(1'b0);
    play_round(1'b1);
    press();
    press();
    checks++;
    if (fire_en !== 1'b1 || score0 !== 3'd2 || player !== 1'b1) begin
      errors++; $display("FAIL pre_reset got fe=%b s0=%0d p=%0d want 1 2 1", fire_en, score0, player);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (flags() !== 5'b00000 || score0 !== 3'd0 || score1 !== 3'd0 || player !== 1'b0) begin
      errors++; $display("FAIL reset_in_fire got flags=%b s0=%0d s1=%0d p=%0d want 00000 0 0 0",
                         flags(), score0, score1, player);
    end
    checks++;
    if (angle_q !== 8'd0 || power_q !== 8'd0) begin
      errors++; $display("FAIL reset_in_fire_q got aq=%0d pq=%0d want 0 0", angle_q, power_q);
    end
    press();
    checks++;
    if (flags() !== 5'b10001) begin
      errors++; $display("FAIL restart_after_reset got %b want 10001", flags());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; go = 1'b0; fire_done = 1'b0; hit = 1'b0;
    angle_in = 8'd0; power_in = 8'd0;
    ang_x = 8'h11;  ang_y = 7'h22;  ang_color = 3'd1;
    pow_x = 8'h33;  pow_y = 7'h44;  pow_color = 3'd2;
    fire_x = 8'h55; fire_y = 7'h66; fire_color = 3'd3;
    test_reset();
    test_go_to_angle();
    test_angle_power_capture();
    test_ignore_go_in_fire();
    test_hit_and_result();
    test_hold_go();
    test_win();
    test_reset_mid_fire();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
